clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel, runtime-programmable clock-enable/clock divider for the fabric clock domain. Each channel divides `clk_in` by its own integer ratio, changed at runtime, and produces a square-wave `clk_out` and a single-cycle `tick` strobe. Ratio changes take effect only at a period boundary, so outputs never glitch. It replaces fixed power-of-two dividers wherever peripherals need arbitrary, runtime-selectable rates.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `WIDTH`, 16: divisor and counter width in bits.
- `DEFAULT_DIV`, 2: divisor loaded into every channel at reset (0 or ≥2).
- `clk_in` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce` in 1: global count enable. Counters advance only when high.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: write accepted this cycle when `cfg_valid & cfg_ready`.
- `cfg_chan` in max(1,$clog2(CHANNELS)): target channel.
- `cfg_div` in WIDTH: new divisor. 0 stops the channel. 1 is clamped to 2.
- `clk_out` out CHANNELS: divided square wave per channel.
- `tick` out CHANNELS: one-`clk_in`-cycle strobe, once per divided period.
- `pending` out CHANNELS: a staged divisor is waiting for the period boundary.

## Operation
- Per-channel state:
  - `cnt[WIDTH]`
  - `div_act` (active divisor)
  - `div_stg` (staged divisor)
  - `pending`
- Reset values:
  - `cnt`=0, `div_act`=DEFAULT_DIV, `div_stg`=0.
  - `pending`=0, `clk_out`=0, `tick`=0.
- Counting, when `ce`=1 and `div_act`≠0:
  - `cnt` steps 0→1→…→D-1→0, where D=`div_act`.
  - The cycle with `cnt`=D-1 is the wrap cycle.
- Duty cycle: `clk_out` is the registered value of (`cnt` < H), with H=ceil(D/2).
  - Even D gives 50% duty.
  - Odd D is high for one extra count.
- Freezing: when `ce`=0, `cnt` and `clk_out` hold and `tick`=0.
- Stopped channel (`div_act`=0):
  - `cnt` is held at 0, `clk_out`=0, `tick`=0.
- `cfg_ready` = !`pending[cfg_chan]`.
  - It is 1 for an out-of-range `cfg_chan`; such writes are accepted and discarded.
- Accepted write to a stopped channel:
  - `div_act` is loaded directly in the next cycle and `cnt`=0.
  - `pending` is never set.
- Accepted write to a running channel:
  - `div_stg` is loaded and `pending` is set.
  - At the next wrap cycle, `div_act`←`div_stg`, `cnt`←0 and `pending` clears.
- Write in the same cycle as a wrap: it is staged and applies at the following wrap, not the current one.
- Staged 0: the channel finishes its current period, then stops with `clk_out` low.
- Divisors are unsigned with no overflow; the maximum is 2^WIDTH−1.
- `rst` mid-period:
  - Everything returns to reset values on the next edge, and staged writes are lost.
  - `rst` overrides `ce`, `cfg_valid` and `sync`.

## Timing
- Wrap cycle k with `ce`=1 → `tick` high in cycle k+1 only.
- `clk_out` lags `cnt` by one cycle.
- After `rst` deasserts, with `ce`=1 and D=4:
  - `cnt` runs 0,1,2,3 in cycles 0–3.
  - `tick` is high in cycle 4.
  - `clk_out` is high in cycles 1–2 and low in cycles 3–4.
- Config latency:
  - Stopped channel: one cycle from accept to counting.
  - Running channel: applied on the first wrap strictly after the accept cycle.
- `cfg_ready` is combinational from `pending` and `cfg_chan`. It does not depend on `cfg_valid`.

## Configuration
- Macro `CLK_DIV_MULTI_SYNC_EN`.
- Defined:
  - Adds input `sync` (1 bit).
  - When `sync`=1, regardless of `ce`: every channel applies its staged divisor (if `pending`), clears `pending` and sets `cnt`=0.
  - No `tick` is generated by a `sync`.
  - Channels are phase-aligned from the next cycle.
  - `sync` takes priority over a wrap in the same cycle.
  - A cfg accept in the same cycle as `sync` is staged after the sync is applied.
- Undefined: the `sync` port and its logic are absent.

## Structure
- Package `clk_div_multi_pkg`:
  - `div_t` (logic [WIDTH-1:0])
  - `DIV_STOP`=0 and `DIV_MIN`=2
  - function `div_clamp()` mapping 1→2
  - function `div_half()` returning ceil(D/2)
- Sub-module `clk_div_chan`: one channel (counter, active/staged divisor, duty compare, tick).
  - Instantiated CHANNELS times by a generate loop.
  - The top level holds channel decode and the `cfg_ready` mux.

## Test plan
- Reset, `ce`=1, DEFAULT_DIV=2 → every `clk_out` toggles every cycle starting at cycle 1, and `tick` fires every 2nd cycle.
- Write ch1 D=5 → `clk_out[1]` is high for 3 cycles and low for 2, and `tick[1]` has period 5. Other channels are unaffected.
- Write ch0 D=8 mid-period of D=4 → `pending[0]`=1 and `cfg_ready`=0 for ch0. The current 4-cycle period completes, then 8-cycle periods follow and `pending` clears at the wrap.
- Write D=0 to a running channel → it stops low after the current period. A later write of D=3 → a 3-cycle period starts one cycle after accept. A write of D=1 → behaves as D=2.
- Toggle `ce` at 25% over D=4 → the period stretches to 16 `clk_in` cycles and `tick` is never asserted while `ce`=0. Assert `rst` mid-period → all outputs read 0 on the next cycle.
- With `CLK_DIV_MULTI_SYNC_EN`, ch0 D=4 and ch1 D=6 in arbitrary phase, pulse `sync` → both `cnt` read 0 the next cycle and `tick`s coincide every 12 cycles. The `sync` cycle produces no `tick`.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
// Helpers work on 32-bit values; callers zero-extend and truncate to WIDTH.
package clk_div_multi_pkg;

    localparam int unsigned DIV_W = 16;

    typedef logic [DIV_W-1:0] div_t;

    localparam logic [31:0] DIV_STOP = 32'd0;
    localparam logic [31:0] DIV_MIN  = 32'd2;

    // A divisor of 1 cannot form a square wave, so it runs as 2.
    function automatic logic [31:0] div_clamp(input logic [31:0] d);
        return (d == 32'd1) ? DIV_MIN : d;
    endfunction

    // ceil(d/2) without the d+1 overflow at the top of the range.
    function automatic logic [31:0] div_half(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/staged divisor, duty compare, tick.
// Optional CLK_DIV_MULTI_SYNC_EN adds i_sync (phase-align, apply staged divisor).
module clk_div_chan
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
`ifdef CLK_DIV_MULTI_SYNC_EN
    input  logic             i_sync,
`endif
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_div,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pending
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(div_clamp(32'(DEFAULT_DIV)));
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_div_stg;
    logic             r_pending;
    logic             r_clk;
    logic             r_tick;

    logic             w_run;
    logic             w_wrap;
    logic             w_high;
    logic             w_sync;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_new_div;

`ifdef CLK_DIV_MULTI_SYNC_EN
    assign w_sync = i_sync;
`else
    assign w_sync = 1'b0;
`endif

    assign w_run     = (r_div_act != WIDTH'(DIV_STOP));
    assign w_wrap    = i_ce & w_run & (r_cnt == (r_div_act - ONE));
    assign w_half    = WIDTH'(div_half(32'(r_div_act)));
    assign w_high    = (r_cnt < w_half);
    assign w_new_div = WIDTH'(div_clamp(32'(i_wr_div)));

    // Counter/divisor state; later assignments take priority (sync over wrap,
    // then a write accepted this cycle is staged on top of the result).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_div_act <= RST_DIV;
            r_div_stg <= '0;
            r_pending <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (!w_run) begin
                r_cnt <= '0;
                r_clk <= 1'b0;
            end else if (i_ce) begin
                r_cnt  <= w_wrap ? '0 : r_cnt + ONE;
                r_clk  <= w_high;
                r_tick <= w_wrap;
                if (w_wrap && r_pending) begin
                    r_div_act <= r_div_stg;
                    r_pending <= 1'b0;
                end
            end
            if (w_sync) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
                if (r_pending) begin
                    r_div_act <= r_div_stg;
                    r_pending <= 1'b0;
                end
            end
            // Accept implies no pending stage, so r_div_act is unchanged above.
            if (i_wr && !r_pending) begin
                if (!w_run) begin
                    r_div_act <= w_new_div;
                    r_cnt     <= '0;
                end else begin
                    r_div_stg <= w_new_div;
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign o_clk     = r_clk;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider: channel decode, cfg_ready
// mux and one clk_div_chan per channel.
// Optional macro CLK_DIV_MULTI_SYNC_EN adds the sync input.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter  int unsigned CHANNELS    = 4,
    parameter  int unsigned WIDTH       = 16,
    parameter  int unsigned DEFAULT_DIV = 2,
    localparam int unsigned CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                ce,
`ifdef CLK_DIV_MULTI_SYNC_EN
    input  logic                sync,
`endif
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    logic [CHANNELS-1:0] w_pending;
    logic [CHANNELS-1:0] w_wr;
    logic                w_ready;
    logic                w_acc;

    // Ready mux: out-of-range channels are always ready (writes discarded).
    always_comb begin
        w_ready = 1'b1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CHAN_W'(i)) begin
                w_ready = !w_pending[i];
            end
        end
    end

    assign w_acc     = cfg_valid & w_ready;
    assign cfg_ready = w_ready;
    assign pending   = w_pending;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_wr[g] = w_acc & (cfg_chan == CHAN_W'(g));

        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .i_clk     (clk_in),
            .i_rst     (rst),
            .i_ce      (ce),
`ifdef CLK_DIV_MULTI_SYNC_EN
            .i_sync    (sync),
`endif
            .i_wr      (w_wr[g]),
            .i_wr_div  (cfg_div),
            .o_clk     (clk_out[g]),
            .o_tick    (tick[g]),
            .o_pending (w_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (4 channels, 16-bit, DEFAULT_DIV=2).
// Cycle numbers in comments count clk_in edges since reset release.
module tb_clk_div_multi;

    localparam int unsigned CH = 4;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          ce;
`ifdef CLK_DIV_MULTI_SYNC_EN
    logic          sync;
`endif
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [15:0]   cfg_div;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] pending;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic [63:0] obs_clk  [CH];
    logic [63:0] obs_tick [CH];

    clk_div_multi #(
        .CHANNELS    (CH),
        .WIDTH       (16),
        .DEFAULT_DIV (2)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .ce        (ce),
`ifdef CLK_DIV_MULTI_SYNC_EN
        .sync      (sync),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_obs();
        for (int c = 0; c < CH; c++) begin
            obs_clk[c]  = '0;
            obs_tick[c] = '0;
        end
    endtask

    // Shift in the current sample; pattern literals read left-to-right in time.
    task automatic record();
        for (int c = 0; c < CH; c++) begin
            obs_clk[c]  = {obs_clk[c][62:0], clk_out[c]};
            obs_tick[c] = {obs_tick[c][62:0], tick[c]};
        end
    endtask

    task automatic run(input int n);
        clear_obs();
        for (int k = 0; k < n; k++) begin
            step();
            record();
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] d);
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_div   = d;
    endtask

    initial begin
        rst       = 1'b1;
        ce        = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
`ifdef CLK_DIV_MULTI_SYNC_EN
        sync      = 1'b0;
`endif
        repeat (3) step();
        check("rst_clk", clk_out, 4'h0);
        check("rst_tick", tick, 4'h0);
        check("rst_pend", pending, 4'h0);
        check("rst_ready", cfg_ready, 1'b1);

        // Default divide-by-2 on all channels.
        rst = 1'b0;                                 // cycle 0
        run(8);                                     // cycles 1..8
        check("d2_clk0", obs_clk[0], 8'b10101010);
        check("d2_tick0", obs_tick[0], 8'b01010101);
        check("d2_clk3", obs_clk[3], 8'b10101010);
        check("d2_tick_all", tick, 4'hF);

        // ch1 -> D=5, staged while running, applied at wrap in cycle 9.
        cfg(2'd1, 16'd5);
        #1 check("ready_idle", cfg_ready, 1'b1);
        step();                                     // cycle 9
        cfg_valid = 1'b0;
        #1;
        check("pend_ch1", pending, 4'b0010);
        check("ready_busy_ch1", cfg_ready, 1'b0);
        run(10);                                    // cycles 10..19
        check("d5_clk1", obs_clk[1], 10'b0111001110);
        check("d5_tick1", obs_tick[1], 10'b1000010000);
        check("d5_clk0_unaffected", obs_clk[0], 10'b0101010101);
        check("d5_pend_clear", pending, 4'h0);

        // ch0 -> D=4, then D=8 mid-period.
        step();                                     // cycle 20
        cfg(2'd0, 16'd4);
        step();                                     // cycle 21
        cfg_valid = 1'b0;
        run(6);                                     // cycles 22..27
        check("d4_clk0", obs_clk[0], 6'b011001);
        check("d4_tick0", obs_tick[0], 6'b100010);
        cfg(2'd0, 16'd8);
        #1 check("ready_ch0", cfg_ready, 1'b1);
        step();                                     // cycle 28
        cfg_valid = 1'b0;
        #1;
        check("pend_ch0", pending[0], 1'b1);
        check("ready_busy_ch0", cfg_ready, 1'b0);
        run(18);                                    // cycles 29..46
        check("d8_clk0", obs_clk[0], 18'b001111000011110000);
        check("d8_tick0", obs_tick[0], 18'b010000000100000001);
        check("d8_pend_clear", pending, 4'h0);

        // Staged 0: finish the current 8-cycle period, then stop low.
        cfg(2'd0, 16'd0);
        step();                                     // cycle 47
        cfg_valid = 1'b0;
        run(10);                                    // cycles 48..57
        check("stop_clk0", obs_clk[0], 10'b1110000000);
        check("stop_tick0", obs_tick[0], 10'b0000001000);
        check("stop_pend", pending, 4'h0);

        // Stopped channel loads directly: D=3 counts from the next cycle.
        cfg(2'd0, 16'd3);
        step();                                     // cycle 58
        cfg_valid = 1'b0;
        #1 check("direct_no_pend", pending, 4'h0);
        run(6);                                     // cycles 59..64
        check("d3_clk0", obs_clk[0], 6'b110110);
        check("d3_tick0", obs_tick[0], 6'b001001);

        // D=1 runs as D=2.
        cfg(2'd0, 16'd1);
        step();                                     // cycle 65
        cfg_valid = 1'b0;
        run(6);                                     // cycles 66..71
        check("d1_clk0", obs_clk[0], 6'b101010);
        check("d1_tick0", obs_tick[0], 6'b010101);

        // ch2 -> D=4 written on a wrap cycle: applies at the following wrap.
        cfg(2'd2, 16'd4);
        step();                                     // cycle 72
        cfg_valid = 1'b0;
        #1;
        check("wrapwr_pend", pending, 4'b0100);
        check("wrapwr_tick72", tick[2], 1'b1);
        step();                                     // cycle 73
        check("wrapwr_tick73", tick[2], 1'b0);
        step();                                     // cycle 74
        check("wrapwr_tick74", tick[2], 1'b1);
        check("wrapwr_pend_clear", pending, 4'h0);

        // ce high one cycle in four: 16-cycle period on ch2.
        clear_obs();
        for (int k = 0; k < 29; k++) begin
            ce = (k % 4 == 0);
            step();
            record();                               // cycles 75..103
        end
        ce = 1'b1;
        check("ce_clk2", obs_clk[2], 29'b11111111000000001111111100000);
        check("ce_tick2", obs_tick[2], 29'b00000000000010000000000000001);

        // Reset mid-period with a staged write outstanding.
        cfg(2'd1, 16'd7);
        step();                                     // cycle 104
        cfg_valid = 1'b0;
        #1 check("pre_rst_pend", pending, 4'b0010);
        rst = 1'b1;
        step();
        check("rst_mid_clk", clk_out, 4'h0);
        check("rst_mid_tick", tick, 4'h0);
        check("rst_mid_pend", pending, 4'h0);
        rst = 1'b0;
        run(4);
        check("post_rst_clk1", obs_clk[1], 4'b1010);
        check("post_rst_tick1", obs_tick[1], 4'b0101);

`ifdef CLK_DIV_MULTI_SYNC_EN
        // ch0 D=4, ch1 D=6; sync on a cycle where both wrap.
        rst = 1'b1;
        step();
        rst = 1'b0;                                 // s0
        cfg(2'd0, 16'd4);
        step();                                     // s1
        cfg(2'd1, 16'd6);
        step();                                     // s2
        cfg_valid = 1'b0;
        repeat (7) step();                          // s9
        sync = 1'b1;
        step();                                     // s10
        sync = 1'b0;
        check("sync_no_tick", tick, 4'h0);
        run(12);                                    // s11..s22
        check("sync_tick0", obs_tick[0], 12'b000100010001);
        check("sync_tick1", obs_tick[1], 12'b000001000001);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
